// File: rtl/spa_pkg.sv
// Shared encodings, FSM states and strobe helper for the DPM scratchpad sequencer.
// Optional bypass support in spa_ctl is enabled with the SPA_BYPASS_EN macro.
package spa_pkg;

  localparam int unsigned SPA_NREG = 16;

  localparam logic [1:0] SPA_TMP  = 2'd0;
  localparam logic [1:0] SPA_GPR  = 2'd1;
  localparam logic [1:0] SPA_IPR  = 2'd2;
  localparam logic [1:0] SPA_NONE = 2'd3;

  localparam logic [1:0] DT_BYTE = 2'd0;
  localparam logic [1:0] DT_WORD = 2'd1;
  localparam logic [1:0] DT_LONG = 2'd2;
  localparam logic [1:0] DT_QUAD = 2'd3;

  typedef enum logic [1:0] {StIdle, StWr, StWrQ2} spa_state_e;

  // Active-low byte enables; quads write a full longword per half.
  function automatic logic [3:0] dt_to_spw(input logic [1:0] dt);
    logic [3:0] spw;
    case (dt)
      DT_BYTE: spw = 4'hE;
      DT_WORD: spw = 4'hC;
      default: spw = 4'h0;
    endcase
    return spw;
  endfunction

endpackage

// File: rtl/spa_bank_dec.sv
// Bank number plus enable to active-low chip selects {ipr, gpr, tmp}.
module spa_bank_dec
  import spa_pkg::*;
(
  input  logic [1:0] bank,
  input  logic       en,
  output logic [2:0] cs_l
);

  always_comb begin
    cs_l = 3'b111;
    if (en) begin
      case (bank)
        SPA_TMP: cs_l[0] = 1'b0;
        SPA_GPR: cs_l[1] = 1'b0;
        SPA_IPR: cs_l[2] = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spa_ctl.sv
// Scratchpad address/strobe sequencer: multiplexes posted writes against reads on the
// single array address port. Define SPA_BYPASS_EN to add same-address read bypass (byp_h).
module spa_ctl
  import spa_pkg::*;
#(
  parameter  int unsigned NREG = SPA_NREG,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk_h,
  input  logic          rst_l,
  input  logic          rd_req_h,
  input  logic [1:0]    rd_bank_h,
  input  logic [AW-1:0] rd_addr_h,
  input  logic          wr_req_h,
  input  logic [1:0]    wr_bank_h,
  input  logic [AW-1:0] wr_addr_h,
  input  logic [1:0]    wr_dt_h,
  output logic [AW-1:0] rspa_h,
  output logic          rcs_tmp_l,
  output logic          rcs_gpr_l,
  output logic          rcs_ipr_l,
  output logic [3:0]    spw_l,
  output logic          quad_hi_h,
`ifdef SPA_BYPASS_EN
  output logic          byp_h,
`endif
  output logic          stall_h
);

  spa_state_e    state_q;
  logic [1:0]    pend_bank_q;
  logic [1:0]    pend_dt_q;
  logic [AW-1:0] pend_addr_q;

  logic [AW-1:0] eff_addr;
  logic          conflict;
  logic          byp;
  logic          stall_int;
  logic          post;
  logic [2:0]    rd_cs_l;
  logic [2:0]    wr_cs_l;
  logic [2:0]    cs_l;

  assign eff_addr = (state_q == StWrQ2) ? pend_addr_q + 1'b1 : pend_addr_q;
  assign conflict = rd_req_h && (state_q != StIdle);

`ifdef SPA_BYPASS_EN
  assign byp = conflict && (rd_bank_h == pend_bank_q) && (rd_bank_h != SPA_NONE) &&
               (rd_addr_h == eff_addr);
`else
  assign byp = 1'b0;
`endif

  // The quad's first half always stalls so the next microword cannot overrun the second.
  assign stall_int = (conflict && !byp) || (state_q == StWr && pend_dt_q == DT_QUAD);
  assign post      = wr_req_h && !stall_int;

  spa_bank_dec u_rd_dec (
    .bank (rd_bank_h),
    .en   (rd_req_h),
    .cs_l (rd_cs_l)
  );

  spa_bank_dec u_wr_dec (
    .bank (pend_bank_q),
    .en   (1'b1),
    .cs_l (wr_cs_l)
  );

  always_comb begin
    rspa_h    = '0;
    cs_l      = 3'b111;
    spw_l     = 4'hF;
    quad_hi_h = 1'b0;
    if (rst_l) begin
      case (state_q)
        StIdle: begin
          rspa_h = rd_addr_h;
          cs_l   = rd_cs_l;
        end
        StWr: begin
          rspa_h = pend_addr_q;
          cs_l   = wr_cs_l;
          spw_l  = (pend_bank_q == SPA_NONE) ? 4'hF : dt_to_spw(pend_dt_q);
        end
        StWrQ2: begin
          rspa_h    = eff_addr;
          cs_l      = wr_cs_l;
          spw_l     = (pend_bank_q == SPA_NONE) ? 4'hF : 4'h0;
          quad_hi_h = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {rcs_ipr_l, rcs_gpr_l, rcs_tmp_l} = cs_l;
  assign stall_h = rst_l && stall_int;
`ifdef SPA_BYPASS_EN
  assign byp_h = rst_l && byp && !stall_int;
`endif

  always_ff @(posedge clk_h) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      pend_bank_q <= '0;
      pend_dt_q   <= '0;
      pend_addr_q <= '0;
    end else begin
      if (state_q == StWr && pend_dt_q == DT_QUAD) begin
        state_q <= StWrQ2;
      end else begin
        state_q <= post ? StWr : StIdle;
      end
      if (post) begin
        pend_bank_q <= wr_bank_h;
        pend_dt_q   <= wr_dt_h;
        pend_addr_q <= wr_addr_h;
      end
    end
  end

endmodule

// File: tb/tb_spa_ctl.sv
// Scoreboard bench for spa_ctl; byp_h is checked only when built with SPA_BYPASS_EN.
module tb_spa_ctl;

`ifdef SPA_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic       clk_h = 1'b0;
  logic       rst_l = 1'b0;
  logic       rd_req_h = 1'b0;
  logic [1:0] rd_bank_h = 2'd3;
  logic [3:0] rd_addr_h = 4'd0;
  logic       wr_req_h = 1'b0;
  logic [1:0] wr_bank_h = 2'd0;
  logic [3:0] wr_addr_h = 4'd0;
  logic [1:0] wr_dt_h = 2'd0;
  logic [3:0] rspa_h;
  logic       rcs_tmp_l, rcs_gpr_l, rcs_ipr_l;
  logic [3:0] spw_l;
  logic       quad_hi_h;
  logic       stall_h;
  logic       byp_h;

  always #5 clk_h = ~clk_h;

  spa_ctl dut (
    .clk_h     (clk_h),
    .rst_l     (rst_l),
    .rd_req_h  (rd_req_h),
    .rd_bank_h (rd_bank_h),
    .rd_addr_h (rd_addr_h),
    .wr_req_h  (wr_req_h),
    .wr_bank_h (wr_bank_h),
    .wr_addr_h (wr_addr_h),
    .wr_dt_h   (wr_dt_h),
    .rspa_h    (rspa_h),
    .rcs_tmp_l (rcs_tmp_l),
    .rcs_gpr_l (rcs_gpr_l),
    .rcs_ipr_l (rcs_ipr_l),
    .spw_l     (spw_l),
    .quad_hi_h (quad_hi_h),
`ifdef SPA_BYPASS_EN
    .byp_h     (byp_h),
`endif
    .stall_h   (stall_h)
  );

`ifndef SPA_BYPASS_EN
  assign byp_h = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [3:0] rspa;
    logic [2:0] cs;     // {ipr, gpr, tmp}
    logic [3:0] spw;
    logic       qhi;
    logic       stall;
    logic       byp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one microword after the edge, queue its expectation, compare mid-cycle.
  task automatic step(input string tag, input logic rst, input logic rr,
                      input logic [1:0] rb, input logic [3:0] ra, input logic wr,
                      input logic [1:0] wb, input logic [3:0] wa, input logic [1:0] wd,
                      input logic [3:0] e_rspa, input logic [2:0] e_cs,
                      input logic [3:0] e_spw, input logic e_qhi, input logic e_stall,
                      input logic e_byp);
    exp_t e;
    @(posedge clk_h);
    #1;
    rst_l = rst; rd_req_h = rr; rd_bank_h = rb; rd_addr_h = ra;
    wr_req_h = wr; wr_bank_h = wb; wr_addr_h = wa; wr_dt_h = wd;
    sb.push_back('{tag: tag, rspa: e_rspa, cs: e_cs, spw: e_spw, qhi: e_qhi,
                   stall: e_stall, byp: e_byp});
    #4;
    e = sb.pop_front();
    check({e.tag, ".rspa"}, 32'(rspa_h), 32'(e.rspa));
    check({e.tag, ".rcs"}, 32'({rcs_ipr_l, rcs_gpr_l, rcs_tmp_l}), 32'(e.cs));
    check({e.tag, ".spw"}, 32'(spw_l), 32'(e.spw));
    check({e.tag, ".qhi"}, 32'(quad_hi_h), 32'(e.qhi));
    check({e.tag, ".stall"}, 32'(stall_h), 32'(e.stall));
    if (Byp) check({e.tag, ".byp"}, 32'(byp_h), 32'(e.byp));
  endtask

  initial begin
    //   tag            rst rr rb  ra  wr wb  wa  wd  rspa cs      spw  qhi stl byp
    step("rst_hold",     0, 0, 3,  0,  0, 0,  0, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    step("rst_post_q",   1, 0, 3,  0,  1, 0, 15, 3,   0, 3'b111, 4'hF, 0, 0, 0);
    step("rst_mid_wr",   0, 0, 3,  0,  0, 0,  0, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    step("rst_mid_2",    0, 0, 3,  0,  0, 0,  0, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    step("rst_idle",     1, 0, 3,  6,  0, 0,  0, 0,   6, 3'b111, 4'hF, 0, 0, 0);
    step("rd_gpr5",      1, 1, 1,  5,  0, 0,  0, 0,   5, 3'b101, 4'hF, 0, 0, 0);
    step("wr_ipr9_post", 1, 0, 3,  0,  1, 2,  9, 1,   0, 3'b111, 4'hF, 0, 0, 0);
    step("wr_ipr9",      1, 0, 3,  0,  0, 0,  0, 0,   9, 3'b011, 4'hC, 0, 0, 0);
    step("wr_ipr9_done", 1, 0, 3,  0,  0, 0,  0, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    step("quad_post",    1, 0, 3,  0,  1, 0, 15, 3,   0, 3'b111, 4'hF, 0, 0, 0);
    step("quad_lo",      1, 0, 3,  0,  0, 0,  0, 0,  15, 3'b110, 4'h0, 0, 1, 0);
    step("quad_hi",      1, 0, 3,  0,  0, 0,  0, 0,   0, 3'b110, 4'h0, 1, 0, 0);
    step("quad_done",    1, 0, 3,  2,  0, 0,  0, 0,   2, 3'b111, 4'hF, 0, 0, 0);
    step("b2b_post",     1, 0, 3,  0,  1, 1,  4, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    step("b2b_byte",     1, 0, 3,  0,  1, 0,  8, 2,   4, 3'b101, 4'hE, 0, 0, 0);
    step("b2b_long",     1, 0, 3,  0,  1, 3,  1, 2,   8, 3'b110, 4'h0, 0, 0, 0);
    step("b2b_none",     1, 0, 3,  0,  0, 0,  0, 0,   1, 3'b111, 4'hF, 0, 0, 0);
    step("b2b_done",     1, 0, 3,  0,  0, 0,  0, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    step("cf_post",      1, 0, 3,  0,  1, 1,  3, 2,   0, 3'b111, 4'hF, 0, 0, 0);
    step("cf_wr",        1, 1, 1,  7,  0, 0,  0, 0,   3, 3'b101, 4'h0, 0, 1, 0);
    step("cf_rd",        1, 1, 1,  7,  0, 0,  0, 0,   7, 3'b101, 4'hF, 0, 0, 0);
    step("by_post",      1, 0, 3,  0,  1, 1,  3, 2,   0, 3'b111, 4'hF, 0, 0, 0);
    step("by_wr",        1, 1, 1,  3,  0, 0,  0, 0,   3, 3'b101, 4'h0, 0, !Byp, Byp);
    step("by_rd",        1, 1, 1,  3,  0, 0,  0, 0,   3, 3'b101, 4'hF, 0, 0, 0);
    step("sim_rdwr",     1, 1, 0,  2,  1, 2,  6, 2,   2, 3'b110, 4'hF, 0, 0, 0);
    step("sim_wr",       1, 0, 3,  0,  0, 0,  0, 0,   6, 3'b011, 4'h0, 0, 0, 0);
    step("q2_post",      1, 0, 3,  0,  1, 1, 10, 3,   0, 3'b111, 4'hF, 0, 0, 0);
    step("q2_lo",        1, 0, 3,  0,  0, 0,  0, 0,  10, 3'b101, 4'h0, 0, 1, 0);
    step("q2_rd",        1, 1, 2,  4,  0, 0,  0, 0,  11, 3'b101, 4'h0, 1, 1, 0);
    step("q2_rd_done",   1, 1, 2,  4,  0, 0,  0, 0,   4, 3'b011, 4'hF, 0, 0, 0);
    step("hold_post",    1, 0, 3,  0,  1, 0,  1, 2,   0, 3'b111, 4'hF, 0, 0, 0);
    step("hold_stall",   1, 1, 0,  5,  1, 0, 12, 1,   1, 3'b110, 4'h0, 0, 1, 0);
    step("hold_cap",     1, 1, 0,  5,  1, 0, 12, 1,   5, 3'b110, 4'hF, 0, 0, 0);
    step("hold_wr",      1, 0, 3,  0,  0, 0,  0, 0,  12, 3'b110, 4'hC, 0, 0, 0);
    step("hold_done",    1, 0, 3,  0,  0, 0,  0, 0,   0, 3'b111, 4'hF, 0, 0, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spa_ctl.md
Name: spa_ctl

Overview:
- Scratchpad address and strobe sequencer for the DPM.
- Converts microword scratchpad read/write fields into the shared 4-bit scratchpad address, per-bank chip selects and per-byte write enables for the 3-bank (TMP/GPR/IPR) 16x32 scratchpad array.
- The array has one address port, so this block time-multiplexes posted writes against reads and stalls the microsequencer on conflicts.
- Quadword writes are split into two longword writes: Rn, then Rn+1.

Parameters:
- NREG, 16, registers per bank. Address width is log2(NREG) = 4.

Ports:
- clk_h  in  1  DPM clock; all state changes on rising edge.
- rst_l  in  1  reset; synchronous, active-low.
- rd_req_h  in  1  microword requests a scratchpad read this cycle.
- rd_bank_h  in  2  read bank: 0 TMP, 1 GPR, 2 IPR, 3 none.
- rd_addr_h  in  4  read register number.
- wr_req_h  in  1  microword posts a scratchpad write.
- wr_bank_h  in  2  write bank, same encoding as rd_bank_h.
- wr_addr_h  in  4  write register number.
- wr_dt_h  in  2  data type: 0 byte, 1 word, 2 long, 3 quad.
- rspa_h  out  4  scratchpad address to the array.
- rcs_tmp_l, rcs_gpr_l, rcs_ipr_l  out  1 each  bank chip selects, active low.
- spw_l  out  4  byte write enables, active low; bit n strobes byte n.
- quad_hi_h  out  1  high during the second longword of a quad write; steers the upper 32 bits onto wbus_h.
- stall_h  out  1  microsequencer must hold the current microword.

Behaviour:
- Reset (rst_l=0 at an edge):
  - state = IDLE, pending-write register cleared.
  - rspa_h=0, all rcs_*_l=1, spw_l=4'hF, quad_hi_h=0, stall_h=0.
  - Reset mid-operation abandons any pending or second-half quad write.
- Write posting:
  - wr_req_h is sampled at edge N into the pending register: bank, addr, dt.
  - The array write occurs in cycle N+1, when wbus_h carries the result.
- States:
  - IDLE, no pending write:
    - rspa_h = rd_addr_h.
    - The rcs selected by rd_bank_h is low when rd_req_h=1; otherwise all rcs are high.
    - spw_l=F.
  - WR, pending write:
    - rspa_h = pending addr; the rcs for the pending bank is low.
    - spw_l by dt: byte -> E, word -> C, long/quad -> 0.
    - Bank 3 means no rcs asserted and spw_l=F; the write slot is still consumed.
    - quad -> WR_Q2; else IDLE, or WR if a new wr_req_h is present.
  - WR_Q2:
    - rspa_h = (pending addr + 1) mod 16; wraps 15 -> 0.
    - Same bank, spw_l=0, quad_hi_h=1.
    - Next state is IDLE, or WR if a new write is posted.
- Stall:
  - stall_h=1 combinationally in any cycle where rd_req_h=1 and state is WR or WR_Q2. The read is deferred; the microword is held, so rd_*/wr_* inputs are stable next cycle.
  - stall_h=1 in WR when dt=quad, so the second half is not overrun.
  - While stall_h=1, a held wr_req_h is not re-posted; the pending register captures it only on the cycle stall_h falls.
- Back-to-back writes:
  - Writes on consecutive cycles proceed one per cycle with no stall when no reads are requested.
- Simultaneous read and write posting in the same microword:
  - The read is serviced in the current cycle (IDLE).
  - The write happens in the next cycle.

Optional Feature:
- Macro: SPA_BYPASS_EN.
- Defined:
  - A read that conflicts with a pending or second-half write to the same bank and same effective address does not stall.
  - Output byp_h=1 tells the R-bus latch to take the wbus_h value instead.
  - Conflicts to a different address still stall.
  - byp_h resets to 0.
- Undefined:
  - byp_h is absent.
  - All read/write conflicts stall as above.

Decomposition:
- Shared package spa_pkg holds:
  - bank encoding constants SPA_TMP/SPA_GPR/SPA_IPR/SPA_NONE;
  - data-type constants DT_BYTE/DT_WORD/DT_LONG/DT_QUAD;
  - the state enum;
  - function dt_to_spw (dt -> 4-bit active-low enables).
- One sub-module: spa_bank_dec, a 2-bit bank + enable to 3 active-low chip selects. Reused for the read and write paths.

Test Plan:
- Reset: hold rst_l=0 for 2 cycles during a quad write -> all rcs=1, spw_l=F, stall_h=0, state IDLE next cycle.
- Read only: rd_req GPR addr 5 -> rspa_h=5, rcs_gpr_l=0, others 1, spw_l=F, no stall.
- Posted write: wr_req IPR addr 9 word at edge N.
  - Cycle N+1: rspa_h=9, rcs_ipr_l=0, spw_l=C.
  - Cycle N+2: spw_l=F.
- Quad wrap: wr_req TMP addr 15 quad.
  - Cycle N+1: rspa=15, spw_l=0, stall_h=1.
  - Cycle N+2: rspa=0, quad_hi_h=1.
  - Then IDLE.
- Conflict: write GPR 3 long posted; the next microword reads GPR 7.
  - stall_h=1 for one cycle while rspa=3.
  - Next cycle rspa=7, rcs_gpr_l=0.
- Bypass build: same as the conflict case but the read targets GPR 3 -> byp_h=1, stall_h=0. Without the macro -> stall_h=1.
